// File: rtl/seq_stepper_pkg.sv
// Shared types and default widths for the multi-mode sequence stepper.
package seq_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WP_W_DEF   = 64;
    localparam int STEP_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/wp_toggle_detect.sv
// Two-flop tracker of one write-pointer bit; ev is high for one cycle per toggle.
// Reset captures the live bit in both flops so release never produces an event.
module wp_toggle_detect #(
    parameter int WP_W   = 64,
    parameter int WP_BIT = 0
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [WP_W-1:0] write_pointer,
    output logic            ev
);

    logic wp_next_q;
    logic wp_prev_q;
    logic unused_wp;

    // Only one bit is of interest; fold the rest so the port stays fully read.
    assign unused_wp = ^write_pointer;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wp_next_q <= write_pointer[WP_BIT];
            wp_prev_q <= write_pointer[WP_BIT];
        end else begin
            wp_next_q <= write_pointer[WP_BIT];
            wp_prev_q <= wp_next_q;
        end
    end

    assign ev = wp_prev_q ^ wp_next_q;

endmodule

// File: rtl/sequence_stepper_multi.sv
// Armed sequence stepper: counts write-pointer bit toggles, steps every step_size+1 of them,
// wraps at seq_len into periods and stops after num_periods. SEQ_STEPPER_MULTI_LATCH_EN shadows the config per period.
module sequence_stepper_multi
    import seq_stepper_pkg::*;
#(
    parameter int WP_W   = WP_W_DEF,
    parameter int WP_BIT = 0,
    parameter int STEP_W = STEP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [WP_W-1:0]   write_pointer,
    input  logic [STEP_W-1:0] step_size,
    input  logic [CNT_W-1:0]  seq_len,
    input  logic [CNT_W-1:0]  num_periods,
    input  logic              arm,
    output logic [CNT_W-1:0]  seq_counter,
    output logic [CNT_W-1:0]  step_index,
    output logic [CNT_W-1:0]  period_counter,
    output logic              step_pulse,
    output logic              period_pulse,
    output logic              active,
    output logic              done
);

    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
    localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

    state_e            state_q, state_d;
    logic              ev;
    logic              ev_q;
    logic [STEP_W-1:0] step_size_q;
    logic [CNT_W-1:0]  seq_len_q, num_periods_q;
    logic [STEP_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic              step_pulse_q, step_pulse_d;
    logic              period_pulse_q, period_pulse_d;
    logic [STEP_W-1:0] eff_step;
    logic [CNT_W-1:0]  eff_len, eff_np;

    wp_toggle_detect #(
        .WP_W   (WP_W),
        .WP_BIT (WP_BIT)
    ) u_toggle (
        .clk           (clk),
        .aresetn       (aresetn),
        .write_pointer (write_pointer),
        .ev            (ev)
    );

`ifdef SEQ_STEPPER_MULTI_LATCH_EN
    logic [STEP_W-1:0] shadow_step_q, shadow_step_d;
    logic [CNT_W-1:0]  shadow_len_q, shadow_len_d;
    logic [CNT_W-1:0]  shadow_np_q, shadow_np_d;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            shadow_step_q <= '0;
            shadow_len_q  <= '0;
            shadow_np_q   <= '0;
        end else begin
            shadow_step_q <= shadow_step_d;
            shadow_len_q  <= shadow_len_d;
            shadow_np_q   <= shadow_np_d;
        end
    end

    assign eff_step = shadow_step_q;
    assign eff_len  = shadow_len_q;
    assign eff_np   = shadow_np_q;
`else
    assign eff_step = step_size_q;
    assign eff_len  = seq_len_q;
    assign eff_np   = num_periods_q;
`endif

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            ev_q           <= 1'b0;
            step_size_q    <= '0;
            seq_len_q      <= '0;
            num_periods_q  <= '0;
            sample_cnt_q   <= '0;
            seq_q          <= '0;
            idx_q          <= '0;
            per_q          <= '0;
            step_pulse_q   <= 1'b0;
            period_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ev_q           <= ev;
            step_size_q    <= step_size;
            seq_len_q      <= seq_len;
            num_periods_q  <= num_periods;
            sample_cnt_q   <= sample_cnt_d;
            seq_q          <= seq_d;
            idx_q          <= idx_d;
            per_q          <= per_d;
            step_pulse_q   <= step_pulse_d;
            period_pulse_q <= period_pulse_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        seq_d          = seq_q;
        idx_d          = idx_q;
        per_d          = per_q;
        step_pulse_d   = 1'b0;
        period_pulse_d = 1'b0;
`ifdef SEQ_STEPPER_MULTI_LATCH_EN
        shadow_step_d  = shadow_step_q;
        shadow_len_d   = shadow_len_q;
        shadow_np_d    = shadow_np_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d      = RUN;
                    seq_d        = '0;
                    idx_d        = '0;
                    per_d        = '0;
                    sample_cnt_d = step_size_q;
`ifdef SEQ_STEPPER_MULTI_LATCH_EN
                    shadow_step_d = step_size_q;
                    shadow_len_d  = seq_len_q;
                    shadow_np_d   = num_periods_q;
`endif
                end
            end
            RUN: begin
                // Disarm wins over a coincident event, which is discarded.
                if (!arm) begin
                    state_d = IDLE;
                end else if (ev_q) begin
                    if (sample_cnt_q != '0) begin
                        sample_cnt_d = sample_cnt_q - ONE_S;
                    end else begin
                        sample_cnt_d = eff_step;
                        seq_d        = seq_q + ONE_C;
                        step_pulse_d = 1'b1;
                        if ((eff_len != '0) && (idx_q == eff_len - ONE_C)) begin
                            idx_d          = '0;
                            per_d          = per_q + ONE_C;
                            period_pulse_d = 1'b1;
`ifdef SEQ_STEPPER_MULTI_LATCH_EN
                            shadow_step_d  = step_size_q;
                            shadow_len_d   = seq_len_q;
                            shadow_np_d    = num_periods_q;
`endif
                            if ((eff_np != '0) && (per_q + ONE_C == eff_np)) begin
                                state_d = DONE;
                            end
                        end else begin
                            idx_d = idx_q + ONE_C;
                        end
                    end
                end
            end
            DONE: begin
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign seq_counter    = seq_q;
    assign step_index     = idx_q;
    assign period_counter = per_q;
    assign step_pulse     = step_pulse_q;
    assign period_pulse   = period_pulse_q;
    assign active         = (state_q == RUN);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_sequence_stepper_multi.sv
// Directed bench for sequence_stepper_multi: table of configurations plus hand-written corner sequences.
module tb_sequence_stepper_multi;

    logic        clk;
    logic        aresetn;
    logic [63:0] wp;
    logic [31:0] step_size;
    logic [31:0] seq_len;
    logic [31:0] num_periods;
    logic        arm;

    logic [31:0] seq_o, idx_o, per_o;
    logic        sp_o, pp_o, act_o, dn_o;
    logic [3:0]  seq4, idx4, per4;
    logic        sp4, pp4, act4, dn4;

    int checks = 0;
    int failures = 0;

    sequence_stepper_multi dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .write_pointer  (wp),
        .step_size      (step_size),
        .seq_len        (seq_len),
        .num_periods    (num_periods),
        .arm            (arm),
        .seq_counter    (seq_o),
        .step_index     (idx_o),
        .period_counter (per_o),
        .step_pulse     (sp_o),
        .period_pulse   (pp_o),
        .active         (act_o),
        .done           (dn_o)
    );

    sequence_stepper_multi #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .aresetn        (aresetn),
        .write_pointer  (wp),
        .step_size      (step_size),
        .seq_len        (seq_len[3:0]),
        .num_periods    (num_periods[3:0]),
        .arm            (arm),
        .seq_counter    (seq4),
        .step_index     (idx4),
        .period_counter (per4),
        .step_pulse     (sp4),
        .period_pulse   (pp4),
        .active         (act4),
        .done           (dn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ss;
        logic [31:0] len;
        logic [31:0] np;
        int          n;
        logic [31:0] smask;
        logic [31:0] pmask;
        logic [31:0] seq;
        logic [31:0] idx;
        logic [31:0] per;
        logic        act;
        logic        dn;
    } vec_t;

    vec_t vt[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs must move exactly two clocks after the edge that samples the toggle.
    task automatic toggle(input string tag, input logic exp_s, input logic exp_p);
        wp = wp + 64'd1;
        tick();
        tick();
        chk({tag, "_early"}, {31'd0, sp_o}, 32'd0);
        tick();
        chk({tag, "_step"}, {31'd0, sp_o}, {31'd0, exp_s});
        chk({tag, "_per"}, {31'd0, pp_o}, {31'd0, exp_p});
        tick();
        chk({tag, "_width"}, {31'd0, sp_o | pp_o}, 32'd0);
    endtask

    task automatic start(input logic [31:0] ss, input logic [31:0] len, input logic [31:0] np);
        arm = 1'b0;
        tick();
        step_size   = ss;
        seq_len     = len;
        num_periods = np;
        tick();
        tick();
        arm = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] lmask;

        vt[0] = '{ss: 3, len: 0, np: 0, n: 12, smask: 32'h0888, pmask: 32'h0,
                  seq: 3, idx: 3, per: 0, act: 1'b1, dn: 1'b0};
        vt[1] = '{ss: 0, len: 4, np: 2, n: 10, smask: 32'h00FF, pmask: 32'h0088,
                  seq: 8, idx: 0, per: 2, act: 1'b0, dn: 1'b1};
        vt[2] = '{ss: 1, len: 1, np: 0, n: 6, smask: 32'h002A, pmask: 32'h002A,
                  seq: 3, idx: 0, per: 3, act: 1'b1, dn: 1'b0};
        vt[3] = '{ss: 2, len: 3, np: 0, n: 10, smask: 32'h0124, pmask: 32'h0100,
                  seq: 3, idx: 0, per: 1, act: 1'b1, dn: 1'b0};
        vt[4] = '{ss: 0, len: 0, np: 0, n: 17, smask: 32'h1FFFF, pmask: 32'h0,
                  seq: 17, idx: 17, per: 0, act: 1'b1, dn: 1'b0};

        aresetn = 1'b0;
        wp = '0;
        step_size = '0;
        seq_len = '0;
        num_periods = '0;
        arm = 1'b0;
        repeat (3) tick();
        chk("rst_seq", seq_o, 32'd0);
        chk("rst_idx", idx_o, 32'd0);
        chk("rst_per", per_o, 32'd0);
        chk("rst_flags", {28'd0, sp_o, pp_o, act_o, dn_o}, 32'd0);
        chk("rst_seq4", {28'd0, seq4}, 32'd0);
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            start(vt[i].ss, vt[i].len, vt[i].np);
            chk($sformatf("v%0d_armclr", i), seq_o | idx_o | per_o, 32'd0);
            for (int k = 0; k < vt[i].n; k++) begin
                toggle($sformatf("v%0d_t%0d", i, k + 1), vt[i].smask[k], vt[i].pmask[k]);
            end
            chk($sformatf("v%0d_seq", i), seq_o, vt[i].seq);
            chk($sformatf("v%0d_idx", i), idx_o, vt[i].idx);
            chk($sformatf("v%0d_per", i), per_o, vt[i].per);
            chk($sformatf("v%0d_act", i), {31'd0, act_o}, {31'd0, vt[i].act});
            chk($sformatf("v%0d_done", i), {31'd0, dn_o}, {31'd0, vt[i].dn});
            chk($sformatf("v%0d_seq4", i), {28'd0, seq4}, vt[i].seq & 32'hF);
            chk($sformatf("v%0d_idx4", i), {28'd0, idx4}, vt[i].idx & 32'hF);
        end

        // Disarm in the very cycle the step-completing event is processed.
        start(0, 0, 0);
        toggle("drop_t1", 1'b1, 1'b0);
        toggle("drop_t2", 1'b1, 1'b0);
        wp = wp + 64'd1;
        tick();
        tick();
        arm = 1'b0;
        tick();
        chk("drop_pulse", {31'd0, sp_o}, 32'd0);
        chk("drop_active", {31'd0, act_o}, 32'd0);
        chk("drop_seq", seq_o, 32'd2);
        tick();
        chk("drop_seq_hold", seq_o, 32'd2);
        arm = 1'b1;
        tick();
        chk("rearm_clear", seq_o | idx_o | per_o, 32'd0);
        chk("rearm_active", {31'd0, act_o}, 32'd1);

        // Reset mid-step (sample_cnt=2), released with the tracked bit high.
        start(3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            toggle($sformatf("mid_t%0d", k + 1), (k == 3), 1'b0);
        end
        chk("mid_seq", seq_o, 32'd1);
        aresetn = 1'b0;
        tick();
        chk("midrst_seq", seq_o, 32'd0);
        chk("midrst_flags", {28'd0, sp_o, pp_o, act_o, dn_o}, 32'd0);
        wp = wp | 64'd1;
        step_size = 32'd0;
        tick();
        tick();
        aresetn = 1'b1;
        repeat (5) tick();
        chk("rel_seq", seq_o, 32'd0);
        chk("rel_idx", idx_o, 32'd0);
        chk("rel_active", {31'd0, act_o}, 32'd1);

        // seq_len shrinks 4 -> 2 after the first step of period 0.
`ifdef SEQ_STEPPER_MULTI_LATCH_EN
        lmask = 32'h28;
`else
        lmask = 32'h2A;
`endif
        start(0, 4, 0);
        toggle("len_t1", 1'b1, lmask[0]);
        seq_len = 32'd2;
        for (int k = 1; k < 6; k++) begin
            toggle($sformatf("len_t%0d", k + 1), 1'b1, lmask[k]);
        end
        chk("len_seq", seq_o, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
